// File: rtl/axi_read_slave_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Interface   : axi_read_slave_if                                          |
// | Description : AXI3-style read address (AR) and read data (R) channels.   |
// |               The master modport drives AR and RREADY. The slave modport |
// |               drives ARREADY and the R channel.                          |
// | Ports       : ARID/ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  master -> slave  |
// |               ARREADY                                   slave  -> master |
// |               RID/RDATA/RRESP/RLAST/RVALID              slave  -> master |
// |               RREADY                                    master -> slave  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface axi_read_slave_if #(
  parameter int BUS_WIDTH = 32,
  parameter int TAG_BITS  = 4
);
  logic [TAG_BITS-1:0]  ARID;
  logic [BUS_WIDTH-1:0] ARADDR;
  logic [3:0]           ARLEN;
  logic [1:0]           ARSIZE;
  logic [1:0]           ARBURST;
  logic                 ARVALID;
  logic                 ARREADY;
  logic [TAG_BITS-1:0]  RID;
  logic [BUS_WIDTH-1:0] RDATA;
  logic [1:0]           RRESP;
  logic                 RLAST;
  logic                 RVALID;
  logic                 RREADY;

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    input  ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, RREADY,
    output ARREADY, RID, RDATA, RRESP, RLAST, RVALID
  );
endinterface
`default_nettype wire

// File: rtl/axi_read_slave.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : axi_read_slave                                             |
// | Description : AXI3-style read responder. Accepts one FIXED/INCR/WRAP     |
// |               burst of 1-16 beats at a time and returns full aligned     |
// |               words from an internal memory, which is filled through a   |
// |               simple preload write port.                                 |
// | Ports       : ACLK       - clock, all state on rising edge               |
// |               ARESETn    - asynchronous active-low reset                 |
// |               bus        - AR/R channels (axi_read_slave_if.slave)       |
// |               mem_we     - preload write enable                          |
// |               mem_waddr  - preload word address                          |
// |               mem_wdata  - preload data                                  |
// | Options     : AXI_RD_SLVERR_EN - when defined, beats whose word index    |
// |               is >= MEM_DEPTH return RDATA=0 with SLVERR; otherwise the  |
// |               word index wraps modulo MEM_DEPTH and RRESP is OKAY.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module axi_read_slave #(
  parameter int BUS_WIDTH = 32,
  parameter int TAG_BITS  = 4,
  parameter int MEM_DEPTH = 256
) (
  input wire                          ACLK,
  input wire                          ARESETn,
  axi_read_slave_if.slave             bus,
  input wire                          mem_we,
  input wire [$clog2(MEM_DEPTH)-1:0]  mem_waddr,
  input wire [BUS_WIDTH-1:0]          mem_wdata
);

  localparam int c_AW = $clog2(MEM_DEPTH);

  localparam logic [1:0] c_BURST_FIXED = 2'b00;
  localparam logic [1:0] c_BURST_WRAP  = 2'b10;
  localparam logic [1:0] c_RESP_OKAY   = 2'b00;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [BUS_WIDTH-1:0] r_mem [MEM_DEPTH];

  logic                 r_arready;
  logic                 r_rvalid;
  logic                 r_rlast;
  logic [TAG_BITS-1:0]  r_id;
  logic [BUS_WIDTH-1:0] r_rdata;
  logic [1:0]           r_rresp;
  logic [BUS_WIDTH-1:0] r_addr;
  logic [3:0]           r_len;
  logic [1:0]           r_size;
  logic [1:0]           r_burst;
  logic [3:0]           r_beat;

  logic                 w_ar_hs;
  logic                 w_beat_hs;
  logic [1:0]           w_size_eff;
  logic [BUS_WIDTH-1:0] w_bytes;
  logic [BUS_WIDTH-1:0] w_incr;
  logic [BUS_WIDTH-1:0] w_wrap_size;
  logic [BUS_WIDTH-1:0] w_lower;
  logic                 w_wrap_ok;
  logic [BUS_WIDTH-1:0] w_next_addr;
  logic [BUS_WIDTH-1:0] w_rd_addr;
  logic [BUS_WIDTH-1:0] w_rd_word;
  logic [BUS_WIDTH-1:0] w_rd_data;
  logic [1:0]           w_rd_resp;
  logic                 w_unused;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ARREADY is registered, so the IDLE state only accepts once ARREADY has
  // actually been presented; this gives the one-edge delay out of reset and
  // after the final beat.
  always_comb begin
    w_state_nxt = r_state;
    w_ar_hs     = 1'b0;
    w_beat_hs   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.ARVALID && r_arready) begin
          w_ar_hs     = 1'b1;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (r_rvalid && bus.RREADY) begin
          w_beat_hs = 1'b1;
          if (r_rlast) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Next-beat address
  // --------------------------------------------------------------------------
  always_comb begin
    // Size 3 (8 bytes) is wider than the bus and is treated as 4 bytes.
    w_size_eff  = (r_size == 2'd3) ? 2'd2 : r_size;
    w_bytes     = BUS_WIDTH'(1) << w_size_eff;
    w_incr      = r_addr + w_bytes;
    w_wrap_ok   = (r_len == 4'd1) || (r_len == 4'd3) ||
                  (r_len == 4'd7) || (r_len == 4'd15);
    w_wrap_size = (BUS_WIDTH'(r_len) + BUS_WIDTH'(1)) << w_size_eff;
    w_lower     = r_addr & ~(w_wrap_size - BUS_WIDTH'(1));
    w_next_addr = w_incr;
    if (r_burst == c_BURST_FIXED) begin
      w_next_addr = r_addr;
    end else if ((r_burst == c_BURST_WRAP) && w_wrap_ok &&
                 (w_incr == (w_lower + w_wrap_size))) begin
      w_next_addr = w_lower;
    end
  end

  // --------------------------------------------------------------------------
  // Memory read path: the word for the beat about to be presented is looked
  // up combinationally and captured into RDATA on the loading edge.
  // --------------------------------------------------------------------------
  assign w_rd_addr = w_ar_hs ? bus.ARADDR : w_next_addr;
  assign w_rd_word = r_mem[w_rd_addr[c_AW+1:2]];

`ifdef AXI_RD_SLVERR_EN
  logic w_oob;
  assign w_oob     = |w_rd_addr[BUS_WIDTH-1:c_AW+2];
  assign w_rd_data = w_oob ? '0 : w_rd_word;
  assign w_rd_resp = w_oob ? 2'b10 : c_RESP_OKAY;
  assign w_unused  = ^w_rd_addr[1:0];
`else
  assign w_rd_data = w_rd_word;
  assign w_rd_resp = c_RESP_OKAY;
  assign w_unused  = ^{w_rd_addr[BUS_WIDTH-1:c_AW+2], w_rd_addr[1:0]};
`endif

  // Preload port. The read above sees the pre-write contents on the same
  // edge, so a coincident load of RDATA returns the old word.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      r_mem[mem_waddr] <= mem_wdata;
    end
  end

  // --------------------------------------------------------------------------
  // Channel registers
  // --------------------------------------------------------------------------
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_id      <= '0;
      r_rdata   <= '0;
      r_rresp   <= c_RESP_OKAY;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_beat    <= '0;
    end else begin
      r_arready <= (w_state_nxt == S_IDLE);
      r_rvalid  <= (w_state_nxt == S_BURST);
      if (w_ar_hs) begin
        r_id    <= bus.ARID;
        r_addr  <= bus.ARADDR;
        r_len   <= bus.ARLEN;
        r_size  <= bus.ARSIZE;
        r_burst <= bus.ARBURST;
        r_beat  <= '0;
        r_rdata <= w_rd_data;
        r_rresp <= w_rd_resp;
        r_rlast <= (bus.ARLEN == 4'd0);
      end else if (w_beat_hs) begin
        if (r_rlast) begin
          r_rlast <= 1'b0;
        end else begin
          r_beat  <= r_beat + 4'd1;
          r_addr  <= w_next_addr;
          r_rdata <= w_rd_data;
          r_rresp <= w_rd_resp;
          r_rlast <= ((r_beat + 4'd1) == r_len);
        end
      end
    end
  end

  assign bus.ARREADY = r_arready;
  assign bus.RVALID  = r_rvalid;
  assign bus.RLAST   = r_rlast;
  assign bus.RID     = r_id;
  assign bus.RDATA   = r_rdata;
  assign bus.RRESP   = r_rresp;

endmodule
`default_nettype wire
